// File: rtl/enemy_formation.sv
// rtl/enemy_formation.sv - enemy grid formation controller: march, descend, kill handshake
package enemy_formation_pkg;
    typedef struct packed {
        logic        alive;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  id;
    } enemy_t;
endpackage

module enemy_formation
    import enemy_formation_pkg::*;
#(
    parameter int NB_ENEMY_Y   = 10,
    parameter int NB_ENEMY_X   = 5,
    parameter int ENEMY_WIDTH  = 32,
    parameter int ENEMY_HEIGHT = 32,
    parameter int SPACING_X    = 48,
    parameter int SPACING_Y    = 36,
    parameter int ORIGIN_X     = 16,
    parameter int ORIGIN_Y     = 8,
    parameter int STEP_X       = 4,
    parameter int STEP_Y       = 16,
    parameter int SCREEN_WIDTH = 800,
    parameter int FLOOR_Y      = 440
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       move_tick,
    input  logic       kill_valid,
    input  logic [3:0] kill_row,
    input  logic [2:0] kill_col,
    output logic       kill_ready,
    output logic       kill_hit,
    output enemy_t     enemies [NB_ENEMY_Y][NB_ENEMY_X],
    output logic [6:0] alive_count,
    output logic       all_dead,
    output logic       reached_bottom
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MARCH   = 2'd1;
    localparam logic [1:0] S_CLEARED = 2'd2;
    localparam logic [1:0] S_BOTTOM  = 2'd3;

    logic [1:0]  state;
    logic [NB_ENEMY_Y-1:0][NB_ENEMY_X-1:0] alive;
    logic [11:0] ox, oy;
    logic        dir_left;
    logic [4:0]  tick_cnt;

    logic [NB_ENEMY_X-1:0] col_any;
    logic [NB_ENEMY_Y-1:0] row_any;
    int          lc, rc, lr;
    logic [4:0]  period;
    logic        do_move, kill_fire, in_range, hit_floor;
    logic [11:0] ox_next, oy_next;
    logic        dir_next;

    assign kill_ready     = (state == S_MARCH);
    assign all_dead       = (state == S_CLEARED);
    assign reached_bottom = (state == S_BOTTOM);

    always_comb begin
        col_any = '0;
        row_any = '0;
        lc = 0;
        rc = 0;
        lr = 0;
        for (int r = 0; r < NB_ENEMY_Y; r++)
            for (int c = 0; c < NB_ENEMY_X; c++)
                if (alive[r][c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
        for (int c = NB_ENEMY_X - 1; c >= 0; c--)
            if (col_any[c]) lc = c;
        for (int c = 0; c < NB_ENEMY_X; c++)
            if (col_any[c]) rc = c;
        for (int r = 0; r < NB_ENEMY_Y; r++)
            if (row_any[r]) lr = r;
    end

    // Counter may sit above period-1 after kills shrink the period; >= keeps it from wrapping.
    assign period  = 5'(alive_count >> 3) + 5'd1;
    assign do_move = (state == S_MARCH) && move_tick && (tick_cnt >= period - 5'd1);

    always_comb begin
        ox_next  = ox;
        oy_next  = oy;
        dir_next = dir_left;
        if (!dir_left) begin
            if ({1'b0, ox} + 13'(rc * SPACING_X + ENEMY_WIDTH + STEP_X) > 13'(SCREEN_WIDTH)) begin
                oy_next  = oy + 12'(STEP_Y);
                dir_next = 1'b1;
            end else begin
                ox_next = ox + 12'(STEP_X);
            end
        end else begin
            if ({1'b0, ox} + 13'(lc * SPACING_X) < 13'(STEP_X)) begin
                oy_next  = oy + 12'(STEP_Y);
                dir_next = 1'b0;
            end else begin
                ox_next = ox - 12'(STEP_X);
            end
        end
        hit_floor = ({1'b0, oy_next} + 13'(lr * SPACING_Y + ENEMY_HEIGHT)) >= 13'(FLOOR_Y);
    end

    assign in_range  = (int'(kill_row) < NB_ENEMY_Y) && (int'(kill_col) < NB_ENEMY_X);
    assign kill_fire = kill_valid && kill_ready && in_range && alive[kill_row][kill_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            alive       <= '0;
            ox          <= '0;
            oy          <= '0;
            dir_left    <= 1'b0;
            tick_cnt    <= '0;
            alive_count <= '0;
            kill_hit    <= 1'b0;
        end else begin
            kill_hit <= 1'b0;
            if (start) begin
                state       <= S_MARCH;
                alive       <= '1;
                ox          <= 12'(ORIGIN_X);
                oy          <= 12'(ORIGIN_Y);
                dir_left    <= 1'b0;
                tick_cnt    <= '0;
                alive_count <= 7'(NB_ENEMY_Y * NB_ENEMY_X);
            end else if (state == S_MARCH) begin
                if (do_move) begin
                    ox       <= ox_next;
                    oy       <= oy_next;
                    dir_left <= dir_next;
                    tick_cnt <= '0;
                end else if (move_tick) begin
                    tick_cnt <= tick_cnt + 5'd1;
                end
                if (kill_fire) begin
                    alive[kill_row][kill_col] <= 1'b0;
                    alive_count               <= alive_count - 7'd1;
                    kill_hit                  <= 1'b1;
                end
                if (kill_fire && alive_count == 7'd1)
                    state <= S_CLEARED;
                else if (do_move && hit_floor)
                    state <= S_BOTTOM;
            end
        end
    end

    // Renderer view is derived from registered origin/bitmap; zeroed until first load.
    always_comb begin
        for (int r = 0; r < NB_ENEMY_Y; r++)
            for (int c = 0; c < NB_ENEMY_X; c++) begin
                enemies[r][c].alive = alive[r][c];
                enemies[r][c].x     = (state != S_IDLE) ? ox + 12'(c * SPACING_X) : 12'd0;
                enemies[r][c].y     = (state != S_IDLE) ? oy + 12'(r * SPACING_Y) : 12'd0;
                enemies[r][c].id    = 2'(r % 3);
            end
    end
endmodule

// File: tb/tb_enemy_formation.sv
// tb/tb_enemy_formation.sv - directed self-checking bench for enemy_formation
module tb_enemy_formation;
    import enemy_formation_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       move_tick = 1'b0;
    logic       kill_valid = 1'b0;
    logic [3:0] kill_row = '0;
    logic [2:0] kill_col = '0;
    logic       kill_ready, kill_hit, all_dead, reached_bottom;
    logic [6:0] alive_count;
    enemy_t     enemies [10][5];

    int n_assert = 0;
    int n_fail   = 0;
    int n_steps;

    enemy_formation dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_tick(move_tick),
        .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
        .kill_ready(kill_ready), .kill_hit(kill_hit), .enemies(enemies),
        .alive_count(alive_count), .all_dead(all_dead), .reached_bottom(reached_bottom)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            move_tick = 1'b1;
            step();
        end
        move_tick = 1'b0;
    endtask

    task automatic kill(input int r, input int c);
        kill_valid = 1'b1;
        kill_row   = 4'(r);
        kill_col   = 3'(c);
        step();
        kill_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_count", alive_count, 0);
        chk("rst_ready", kill_ready, 0);
        chk("rst_hit", kill_hit, 0);
        chk("rst_dead", all_dead, 0);
        chk("rst_bottom", reached_bottom, 0);
        chk("rst_x00", enemies[0][0].x, 0);
        chk("rst_y94", enemies[9][4].y, 0);
        chk("rst_alive00", enemies[0][0].alive, 0);
        chk("rst_id40", enemies[4][0].id, 1);
        rst_n = 1'b1;
        step();

        pulse_start();
        chk("load_count", alive_count, 50);
        chk("load_x00", enemies[0][0].x, 16);
        chk("load_y00", enemies[0][0].y, 8);
        chk("load_x94", enemies[9][4].x, 208);
        chk("load_y94", enemies[9][4].y, 332);
        chk("load_id42", enemies[4][2].id, 1);
        chk("load_id50", enemies[5][0].id, 2);
        chk("load_alive", enemies[3][3].alive, 1);
        chk("load_ready", kill_ready, 1);

        tick(6);
        chk("pace6_x", enemies[0][0].x, 16);
        tick(1);
        chk("pace7_x", enemies[0][0].x, 20);

        tick(973);
        chk("edge_pre_x", enemies[0][0].x, 576);
        chk("edge_pre_y", enemies[0][0].y, 8);
        tick(7);
        chk("edge_desc_x", enemies[0][0].x, 576);
        chk("edge_desc_y", enemies[0][0].y, 24);
        tick(7);
        chk("edge_left_x", enemies[0][0].x, 572);
        chk("edge_left_x04", enemies[0][4].x, 764);

        kill(2, 3);
        chk("kill_hit", kill_hit, 1);
        chk("kill_count", alive_count, 49);
        chk("kill_alive23", enemies[2][3].alive, 0);
        step();
        chk("kill_hit_pulse", kill_hit, 0);
        kill(2, 3);
        chk("rekill_hit", kill_hit, 0);
        chk("rekill_count", alive_count, 49);
        kill(12, 0);
        chk("oor_row_hit", kill_hit, 0);
        chk("oor_row_count", alive_count, 49);
        kill(0, 7);
        chk("oor_col_count", alive_count, 49);

        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 5; c++)
                kill(r, c);
        chk("clear_dead", all_dead, 1);
        chk("clear_ready", kill_ready, 0);
        chk("clear_count", alive_count, 0);
        tick(10);
        chk("clear_frozen_x", enemies[0][0].x, 572);

        pulse_start();
        chk("restart_count", alive_count, 50);
        chk("restart_dead", all_dead, 0);
        chk("restart_x", enemies[0][0].x, 16);
        chk("restart_ready", kill_ready, 1);

        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 5; c++)
                kill(r, c);
        chk("inv_count", alive_count, 5);

        n_steps = 0;
        move_tick = 1'b1;
        while (!reached_bottom && n_steps < 2000) begin
            step();
            n_steps++;
        end
        move_tick = 1'b0;
        chk("inv_moves", n_steps, 721);
        chk("inv_bottom", reached_bottom, 1);
        chk("inv_x90", enemies[9][0].x, 576);
        chk("inv_y90", enemies[9][0].y, 412);
        chk("inv_ready", kill_ready, 0);
        tick(5);
        chk("inv_frozen_x", enemies[9][0].x, 576);
        kill(9, 0);
        chk("inv_kill_ignored", alive_count, 5);

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bottom", reached_bottom, 0);
        chk("async_count", alive_count, 0);
        chk("async_x90", enemies[9][0].x, 0);
        step();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/enemy_formation.md
# enemy_formation

Formation controller for the enemy grid, sitting directly upstream of the enemy sprite renderer. It owns the alive bitmap and the formation origin, and marches the grid sideways on frame ticks. At each screen edge it steps the grid down and reverses direction. It accepts kill requests from collision logic through a valid/ready handshake and drives the `enemies[NB_ENEMY_Y][NB_ENEMY_X]` array of `enemy_t` (`alive`, `x`, `y`, `id`) that the renderer consumes.

## Interface
- `NB_ENEMY_Y`, 10: number of rows (first array index `r`).
- `NB_ENEMY_X`, 5: number of columns (second index `c`).
- `ENEMY_WIDTH` / `ENEMY_HEIGHT`, 32 / 32: sprite size in pixels.
- `SPACING_X` / `SPACING_Y`, 48 / 36: pitch between sprite origins.
- `ORIGIN_X` / `ORIGIN_Y`, 16 / 8: formation origin loaded on start.
- `STEP_X` / `STEP_Y`, 4 / 16: horizontal step and descent per move.
- `SCREEN_WIDTH`, 800: right limit, exclusive.
- `FLOOR_Y`, 440: invasion line.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; (re)loads the formation.
- `move_tick` in 1: one-cycle pulse per frame.
- `kill_valid` in 1: kill request.
- `kill_row` in 4: row index of the kill target.
- `kill_col` in 3: column index of the kill target.
- `kill_ready` out 1: kill request can be accepted.
- `kill_hit` out 1: one-cycle pulse; the accepted kill removed a live enemy.
- `enemies` out `enemy_t[NB_ENEMY_Y][NB_ENEMY_X]`: grid state driven to the renderer.
- `alive_count` out 7: number of live enemies.
- `all_dead` out 1: formation cleared.
- `reached_bottom` out 1: formation touched `FLOOR_Y`.

## Operation
- **States:** IDLE, MARCH, CLEARED, BOTTOM.
  - Reset leads to IDLE.
  - `start` in any state leads to MARCH and performs the load.
- **Load:**
  - All alive bits set to 1.
  - Origin becomes (`ORIGIN_X`, `ORIGIN_Y`).
  - Direction set to right.
  - Tick counter set to 0.
  - `alive_count` set to `NB_ENEMY_Y*NB_ENEMY_X`.
- **Enemy fields:**
  - `enemies[r][c].x` = `ox + c*SPACING_X`.
  - `enemies[r][c].y` = `oy + r*SPACING_Y`.
  - `enemies[r][c].id` = `r mod 3`.
  - `enemies[r][c].alive` = alive bit.
- **Arithmetic:**
  - `x`/`y` are 12 bits.
  - Edge comparisons are done in 13 bits so no wrap occurs.
  - `ox`/`oy` never go below 0.
- **Move pacing:**
  - Move period = `(alive_count >> 3) + 1` ticks.
  - The tick counter increments on `move_tick` in MARCH.
  - When the counter reaches period−1, the counter clears and one move executes.
- **Extents:** computed from the current alive bitmap.
  - `lc` / `rc`: lowest and highest column holding any live enemy.
  - `lr`: highest row holding any live enemy.
- **Move, direction right:**
  - If `ox + rc*SPACING_X + ENEMY_WIDTH + STEP_X > SCREEN_WIDTH`: descend (`oy += STEP_Y`) and set direction to left.
  - Otherwise `ox += STEP_X`.
- **Move, direction left:**
  - If `ox + lc*SPACING_X < STEP_X`: descend and set direction to right.
  - Otherwise `ox -= STEP_X`.
- **Bottom check:** after any move, if `oy + lr*SPACING_Y + ENEMY_HEIGHT >= FLOOR_Y`, go to BOTTOM.
- **Kill handshake:**
  - `kill_ready` = (state == MARCH).
  - Transfer occurs on `kill_valid && kill_ready`.
  - Index out of range: consumed, no effect, `kill_hit`=0.
  - Target alive: bit cleared, `alive_count` decremented, `kill_hit`=1 next cycle.
  - Target already dead: no effect, `kill_hit`=0.
  - `alive_count` reaching 0 moves the state to CLEARED.
- **Kill and move in the same cycle:** both are applied.
  - Extents and period use the pre-kill bitmap and count.
- **Terminal states:**
  - CLEARED: `all_dead`=1.
  - BOTTOM: `reached_bottom`=1.
  - In both, the grid is frozen and ticks and kills are ignored until `start`.
- **`start` with `kill_valid` in the same cycle:** the load wins and the kill is not accepted.

## Timing
- **Reset values:**
  - All `enemies` alive=0, x=0, y=0; id = `r mod 3`.
  - `kill_ready`=0, `kill_hit`=0, `alive_count`=0, `all_dead`=0, `reached_bottom`=0.
  - Direction right, counter 0.
- `enemies`, `alive_count`, `all_dead` and `reached_bottom` are registered. They reflect a load, move or kill on the first rising edge after the event.
- `kill_hit` asserts the cycle after the accepted transfer and lasts exactly 1 cycle.
- `kill_ready` deasserts the cycle after the state leaves MARCH.
- Asserting `rst_n` low mid-march immediately forces all outputs to their reset values, regardless of clock.

## Test plan
- **Load:** reset, then `start`.
  - `alive_count`=50, `enemies[0][0]`=(16,8), `enemies[9][4]`=(208,332), id of row 4 = 1, `kill_ready`=1.
- **Pacing:** after `start`, issue 6 `move_tick` → `ox`=16; the 7th → `ox`=20.
- **Right edge:** march until `ox`=576 (`rc`=4), then one more move.
  - `oy`=24, `ox`=576, direction left; the next move gives `ox`=572.
- **Kill:** kill (2,3).
  - `kill_hit` pulses, `alive_count`=49, `enemies[2][3].alive`=0.
  - Repeating the same kill → `kill_hit`=0, count stays 49.
  - Kill (12,0) → ignored.
- **Clear:** kill all 50 → `all_dead`=1, `kill_ready`=0, later ticks leave `ox` unchanged.
  - `start` → MARCH with 50 alive.
- **Invasion:** preload `oy` by marching with only row 9 alive until `oy + 356 >= 440`.
  - `reached_bottom`=1, grid frozen.
  - Asserting `rst_n` low clears `reached_bottom`.
